// File: rtl/subneg_ctrl_if.sv
// Controller <-> datapath bus for the SUBNEG sequencer: ROM fetch, data-memory
// req/ack handshake, subtractor sign and register-load strobes.
interface subneg_ctrl_if #(
  parameter int unsigned AW = 8
);
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] rom_data;
  logic [AW-1:0] dmem_addr;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ack;
  logic          neg;
  logic          write_op1;
  logic          write_op2;
  logic          write_acc;

  modport master (
    output rom_addr, dmem_addr, dmem_req, dmem_we,
    output write_op1, write_op2, write_acc,
    input  rom_data, dmem_ack, neg
  );

  modport slave (
    input  rom_addr, dmem_addr, dmem_req, dmem_we,
    input  write_op1, write_op2, write_acc,
    output rom_data, dmem_ack, neg
  );
endinterface

// File: rtl/subneg_ctrl.sv
// SUBNEG sequencer: fetches A/B/C, runs memory accesses, resolves branch-if-negative,
// detects the self-loop halt. Optional single-step pause via `define SUBNEG_STEP_EN.
module subneg_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef SUBNEG_STEP_EN
  input  logic              step,
`endif
  subneg_ctrl_if.master     bus,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       instr_cnt
);

  localparam int unsigned CNT_W = 16;

  if (WIDTH == 0 || AW == 0) begin : g_param_check
    $error("subneg_ctrl: WIDTH and AW must be non-zero");
  end

  typedef enum logic [2:0] {
    IDLE,
    FA,
    FB,
    EX,
    BR,
    HALT
`ifdef SUBNEG_STEP_EN
    , PAUSE
`endif
  } state_t;

  state_t            state, state_d;
  logic [AW-1:0]     pc_d, b_q, b_d, base_q, base_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_d;

`ifdef SUBNEG_STEP_EN
  localparam state_t NEXT_INSTR = PAUSE;
`else
  localparam state_t NEXT_INSTR = FA;
`endif

  assign bus.rom_addr = pc;

  // State and architectural registers; busy/halted decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      b_q       <= '0;
      base_q    <= '0;
      neg_q     <= 1'b0;
      instr_cnt <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      b_q       <= b_d;
      base_q    <= base_d;
      neg_q     <= neg_d;
      instr_cnt <= cnt_d;
      busy      <= (state_d == FA) || (state_d == FB) || (state_d == EX) || (state_d == BR);
      halted    <= (state_d == HALT);
    end
  end

  // Next-state, memory handshake and strobes.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    b_d           = b_q;
    base_d        = base_q;
    neg_d         = neg_q;
    cnt_d         = instr_cnt;
    bus.dmem_addr = '0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.write_op1 = 1'b0;
    bus.write_op2 = 1'b0;
    bus.write_acc = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d = FA;
          base_d  = pc;
        end
      end
      FA: begin
        bus.dmem_addr = bus.rom_data;
        bus.dmem_req  = 1'b1;
        if (bus.dmem_ack) begin
          bus.write_op1 = 1'b1;
          pc_d          = pc + AW'(1);
          state_d       = FB;
        end
      end
      FB: begin
        bus.dmem_addr = bus.rom_data;
        bus.dmem_req  = 1'b1;
        if (bus.dmem_ack) begin
          bus.write_op2 = 1'b1;
          b_d           = bus.rom_data;
          pc_d          = pc + AW'(1);
          state_d       = EX;
        end
      end
      EX: begin
        bus.dmem_addr = b_q;
        bus.dmem_req  = 1'b1;
        bus.dmem_we   = 1'b1;
        if (bus.dmem_ack) begin
          bus.write_acc = 1'b1;
          neg_d         = bus.neg;
          state_d       = BR;
        end
      end
      BR: begin
        if (instr_cnt != {CNT_W{1'b1}}) cnt_d = instr_cnt + CNT_W'(1);
        // A taken branch back to the instruction's own base is the halt idiom.
        if (neg_q) begin
          pc_d = bus.rom_data;
          if (bus.rom_data == base_q) begin
            state_d = HALT;
          end else begin
            state_d = NEXT_INSTR;
            base_d  = bus.rom_data;
          end
        end else begin
          pc_d    = pc + AW'(1);
          base_d  = pc + AW'(1);
          state_d = NEXT_INSTR;
        end
      end
`ifdef SUBNEG_STEP_EN
      PAUSE: begin
        if (step) state_d = FA;
      end
`endif
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_subneg_ctrl.sv
// Directed bench for subneg_ctrl: ROM and wait-state memory models, access scoreboard.
module tb_subneg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  pc;
  logic        busy, halted;
  logic [15:0] instr_cnt;
`ifdef SUBNEG_STEP_EN
  logic        step;
`endif

  always #5 clk = ~clk;

  subneg_ctrl_if #(.AW(8)) ifc ();

  subneg_ctrl #(.WIDTH(8), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SUBNEG_STEP_EN
    .step      (step),
`endif
    .bus       (ifc.master),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .instr_cnt (instr_cnt)
  );

  logic [7:0]  rom [256];
  logic        neg_v;
  int          fb_wait, ex_wait, wcnt, cur_wait;
  logic [1:0]  acc_idx;
  logic [31:0] expq [$];
  logic        negq [$];
  logic [31:0] obs, e;
  int          ncmp = 0;
  int          nfail = 0;
  int          op2_pulses;

  assign ifc.rom_data = rom[ifc.rom_addr];
  assign ifc.neg      = neg_v;
  assign ifc.dmem_ack = ifc.dmem_req && (wcnt >= cur_wait);

  // Access index within an instruction: 0=A read, 1=B read, 2=write.
  always_comb begin
    cur_wait = 0;
    if (acc_idx == 2'd1) cur_wait = fb_wait;
    else if (acc_idx == 2'd2) cur_wait = ex_wait;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= 0;
      acc_idx <= 2'd0;
    end else if (ifc.dmem_req && ifc.dmem_ack) begin
      wcnt    <= 0;
      acc_idx <= (acc_idx == 2'd2) ? 2'd0 : acc_idx + 2'd1;
    end else if (ifc.dmem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    ncmp++;
    assert (o === x) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, o, x);
    end
  endtask

  // Record layout: {rom_addr, dmem_addr, 12'b0, we, op1, op2, acc}
  task automatic push_instr(input logic [7:0] p, input logic n);
    logic [7:0] p1, p2;
    p1 = p + 8'd1;
    p2 = p + 8'd2;
    expq.push_back({p,  rom[p],  12'b0, 1'b0, 3'b100});
    expq.push_back({p1, rom[p1], 12'b0, 1'b0, 3'b010});
    expq.push_back({p2, rom[p1], 12'b0, 1'b1, 3'b001});
    negq.push_back(n);
    if (negq.size() == 1) neg_v = n;
  endtask

  task automatic wait_cnt(input logic [15:0] target);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (instr_cnt == target) break;
    end
    chk("retire_cnt", 32'(instr_cnt), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'd0;
    rom[0] = 8'd10;  rom[1] = 8'd11;  rom[2]  = 8'd3;
    rom[3] = 8'd6;   rom[4] = 8'd12;  rom[5]  = 8'd9;
    rom[6] = 8'd20;  rom[7] = 8'd21;  rom[8]  = 8'd6;
    rom[9] = 8'd13;  rom[10] = 8'd14; rom[11] = 8'd254;
    rom[254] = 8'd30; rom[255] = 8'd31;
    rst = 1'b1; start = 1'b0; neg_v = 1'b0; fb_wait = 0; ex_wait = 0;
`ifdef SUBNEG_STEP_EN
    step = 1'b1;
`endif

    // Scoreboard monitor: every completed access is checked in order.
    fork
      forever begin
        @(negedge clk);
        if (!rst && ifc.dmem_req && ifc.dmem_ack) begin
          obs = {ifc.rom_addr, ifc.dmem_addr, 12'b0, ifc.dmem_we,
                 ifc.write_op1, ifc.write_op2, ifc.write_acc};
          if (expq.size() == 0) begin
            ncmp++; nfail++;
            $error("FAIL sb_unexpected: observed %0h, expected no access", obs);
          end else begin
            e = expq.pop_front();
            chk("sb_access", obs, e);
          end
        end
        if (!rst && busy && !ifc.dmem_req && negq.size() > 0) begin
          void'(negq.pop_front());
          neg_v = (negq.size() > 0) ? negq[0] : 1'b0;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_bus", {28'b0, ifc.dmem_req, ifc.write_op1, ifc.write_op2, ifc.write_acc}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req", 32'(ifc.dmem_req), 32'd0);

    push_instr(8'd0, 1'b0);
    push_instr(8'd3, 1'b1);
    push_instr(8'd9, 1'b1);
    push_instr(8'd254, 1'b0);
    push_instr(8'd1, 1'b1);
    push_instr(8'd6, 1'b1);
    start = 1'b1;

    // Zero-wait instruction, cycle by cycle.
    @(negedge clk);
    chk("fa_op1", 32'(ifc.write_op1), 32'd1);
    chk("fa_addr", 32'(ifc.dmem_addr), 32'd10);
    chk("fa_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("fb_op2", 32'(ifc.write_op2), 32'd1);
    chk("fb_addr", 32'(ifc.dmem_addr), 32'd11);
    chk("fb_pc", 32'(pc), 32'd1);
    @(negedge clk);
    chk("ex_acc", 32'(ifc.write_acc), 32'd1);
    chk("ex_addr_we", {23'b0, ifc.dmem_we, ifc.dmem_addr}, {23'b0, 1'b1, 8'd11});
    @(negedge clk);
    chk("br_req", 32'(ifc.dmem_req), 32'd0);
    chk("br_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    chk("i0_pc", 32'(pc), 32'd3);
    chk("i0_cnt", 32'(instr_cnt), 32'd1);

    // Taken branch to 9, then to 254, then wrap to 1.
    wait_cnt(16'd2);
    chk("taken_pc", 32'(pc), 32'd9);
    chk("taken_rom_addr", 32'(ifc.rom_addr), 32'd9);
    wait_cnt(16'd3);
    chk("pre_wrap_pc", 32'(pc), 32'd254);
    wait_cnt(16'd4);
    chk("wrap_pc", 32'(pc), 32'd1);

    // Three wait states on the B read.
    fb_wait = 3;
    op2_pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ws_req", 32'(ifc.dmem_req), 32'd1);
      chk("ws_addr_we", {23'b0, ifc.dmem_we, ifc.dmem_addr}, {23'b0, 1'b0, 8'd3});
      chk("ws_pc", 32'(pc), 32'd2);
      chk("ws_op2", 32'(ifc.write_op2), (k == 3) ? 32'd1 : 32'd0);
      if (ifc.write_op2) op2_pulses++;
    end
    @(negedge clk);
    if (ifc.write_op2) op2_pulses++;
    chk("ws_op2_pulses", 32'(op2_pulses), 32'd1);
    fb_wait = 0;
    wait_cnt(16'd5);
    chk("ws_branch_pc", 32'(pc), 32'd6);
    chk("pre_halt", 32'(halted), 32'd0);

    // Self-loop halt; start is ignored afterwards.
    wait_cnt(16'd6);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pc", 32'(pc), 32'd6);
    start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("halt_hold", {halted, ifc.dmem_req, pc, instr_cnt}, {1'b1, 1'b0, 8'd6, 16'd6});

    rst = 1'b1;
    #1;
    chk("halt_rst", {halted, busy, pc, instr_cnt}, 26'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while the write request is outstanding.
    expq.push_back({8'd0, 8'd10, 12'b0, 1'b0, 3'b100});
    expq.push_back({8'd1, 8'd11, 12'b0, 1'b0, 3'b010});
    neg_v = 1'b0;
    ex_wait = 5;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.dmem_we) break;
    end
    start = 1'b0;
    chk("ex_pending", {ifc.dmem_req, ifc.dmem_we, ifc.write_acc}, 3'b110);
    rst = 1'b1;
    #1;
    chk("exrst_bus", {ifc.dmem_req, ifc.dmem_we, ifc.write_acc}, 3'b000);
    chk("exrst_pc", 32'(pc), 32'd0);
    chk("exrst_cnt", 32'(instr_cnt), 32'd0);
    chk("exrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ex_wait = 0;
    repeat (2) @(negedge clk);
    chk("exrst_idle", {busy, ifc.dmem_req}, 2'b00);
    chk("sb_drain", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/subneg_ctrl.md
Name: subneg_ctrl

Overview:
Sequencer for the SUBNEG one-instruction datapath (PC, op1/op2/acc registers, subtractor, data memory, instruction ROM). It owns the program counter, fetches the three operand words A, B, C of each instruction from ROM, and drives data-memory reads and writes through a req/ack handshake. It strobes the datapath register enables and resolves the branch-if-negative. It also detects the self-loop halt idiom and counts retired instructions.

Parameters:
WIDTH, 8, data word width (informational; the controller carries no data words)
AW, 8, ROM and data-memory address width; PC width

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level; leaves IDLE when sampled high
rom_addr  out  AW  ROM address; always equals pc
rom_data  in  AW  ROM word at rom_addr; combinational, valid in the same cycle
dmem_addr  out  AW  data-memory address
dmem_req  out  1  data-memory request
dmem_we  out  1  write qualifier; meaningful only while dmem_req=1
dmem_ack  in  1  access complete this cycle
neg  in  1  subtractor sign (mem[B]-mem[A] < 0), valid during EX
write_op1  out  1  one-cycle load strobe for op1 (read data of A)
write_op2  out  1  one-cycle load strobe for op2 (read data of B)
write_acc  out  1  one-cycle strobe: result committed to mem[B]
pc  out  AW  current program counter
busy  out  1  high in FA, FB, EX, BR
halted  out  1  high in HALT
instr_cnt  out  16  retired instruction count; saturating

Behaviour:
- Reset (async): state=IDLE, pc=0, instr_cnt=0, b_q=0, base_q=0, neg_q=0. All strobes, dmem_req, dmem_we, busy and halted are 0. Reset mid-transaction abandons any outstanding request.
- States: IDLE, FA, FB, EX, BR, HALT.
- IDLE: start=1 -> FA; base_q<=pc.
- FA: dmem_addr=rom_data, dmem_req=1, dmem_we=0.
  - On dmem_ack: write_op1=1, pc<=pc+1, -> FB.
  - Without ack: hold all outputs.
- FB: dmem_addr=rom_data, dmem_req=1, dmem_we=0.
  - On dmem_ack: write_op2=1, b_q<=rom_data, pc<=pc+1, -> EX.
- EX: dmem_addr=b_q, dmem_req=1, dmem_we=1.
  - On dmem_ack: write_acc=1, neg_q<=neg, -> BR.
- BR: no memory access.
  - neg_q=1: pc<=rom_data. If rom_data==base_q -> HALT; otherwise -> FA with base_q<=rom_data.
  - neg_q=0: pc<=pc+1; -> FA with base_q<=pc+1.
  - Either way, instr_cnt<=instr_cnt+1, saturating at 16'hFFFF. The halting instruction is counted.
- HALT: halted=1; pc frozen. Exits only on rst.
- Strobes are high only in the single ack cycle. dmem_req stays high, with constant addr/we, until ack.
- Minimum latency with zero-wait memory: 4 cycles per instruction (FA, FB, EX, BR).
- PC arithmetic is modulo 2^AW. An instruction at 2^AW-2 fetches A, B, C from 2^AW-2, 2^AW-1 and 0.
- start is ignored outside IDLE.
- Reset asserted in any state returns to IDLE within the same cycle, asynchronously.

Optional Feature:
SUBNEG_STEP_EN
- Defined: adds input step (1 bit) and state PAUSE.
  - BR goes to PAUSE instead of FA; HALT transitions are unchanged.
  - PAUSE: busy=0. step=1 -> FA.
- Undefined: no step port, no PAUSE state; BR goes directly to FA.

Test Plan:
- Zero-wait ack. ROM[0..2]={10,11,3}, mem[10]=2, mem[11]=5, neg=0 in EX -> write_op1 at cycle 1, write_op2 at 2, write_acc at 3 with dmem_addr=11/we=1; pc=3 and instr_cnt=1 after BR.
- Taken branch. Same program, neg=1 in EX, ROM[2]=9 -> pc=9 after BR; the next FA drives rom_addr=9.
- Halt. ROM[6..8]={20,21,6}, neg=1 -> HALT: halted=1, busy=0, pc=6, instr_cnt incremented; start pulses are then ignored.
- Wait states. dmem_ack delayed 3 cycles in FB -> dmem_req, dmem_addr and we stable for 4 cycles, exactly one write_op2 pulse, no pc change until the ack.
- Reset in EX with dmem_req high -> dmem_req, dmem_we, write_acc, pc, instr_cnt all 0 in the same cycle; state IDLE.
- Wrap. pc preset by running to 254 (AW=8), non-negative instruction -> operand fetch addresses 254, 255, 0 and pc=1 after BR.
